// File: rtl/ibex_wb_bridge_if.sv
// Ibex memory port + pipelined Wishbone B4 master signal bundle.
// Ports: master = bridge side, slave = core/bus side; AW address, DW data width.
interface ibex_wb_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic          req_i;
    logic          gnt_o;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [SW-1:0] be_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;

    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_stall_i;

    modport master (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        output wb_adr_o, wb_dat_o
    );

    modport slave (
        output req_i, addr_i, we_i, be_i, wdata_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        input  wb_adr_o, wb_dat_o
    );
endinterface

// File: rtl/ibex_wb_bridge.sv
// Ibex req/gnt/rvalid port to pipelined Wishbone B4 master, in-order responses.
// Ports: clk, rst_n (async low), bus (ibex_wb_bridge_if.master). Macro: IBEX_WB_ERR_EN.
module ibex_wb_bridge #(
    parameter int MAX_OUTS = 2
) (
    input logic             clk,
    input logic             rst_n,
    ibex_wb_bridge_if.master bus
);
    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTS);

    logic [CW-1:0] r_outs;
    logic [CW-1:0] w_outs_nxt;
    logic          w_busy;
    logic          w_stb;
    logic          w_gnt;
    logic          w_cyc;
    logic          w_rvalid;

    // rst_n gates the combinational paths so outputs drop at once in reset.
    assign w_busy   = (r_outs != '0);
    assign w_stb    = rst_n & bus.req_i & (r_outs < MAXC);
    assign w_gnt    = w_stb & ~bus.wb_stall_i;
    assign w_cyc    = w_stb | (rst_n & w_busy);
    // ack/err with nothing outstanding are ignored.
    assign w_rvalid = w_cyc & w_busy & (bus.wb_ack_i | bus.wb_err_i);

    assign bus.wb_stb_o = w_stb;
    assign bus.wb_cyc_o = w_cyc;
    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = w_rvalid;
    assign bus.wb_adr_o = rst_n ? bus.addr_i  : '0;
    assign bus.wb_we_o  = rst_n & bus.we_i;
    assign bus.wb_sel_o = rst_n ? bus.be_i    : '0;
    assign bus.wb_dat_o = rst_n ? bus.wdata_i : '0;
    assign bus.rdata_o  = rst_n ? bus.wb_dat_i : '0;

`ifdef IBEX_WB_ERR_EN
    assign bus.err_o = w_rvalid & bus.wb_err_i;
`else
    // err still terminates the transfer above; it is just not reported.
    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        w_outs_nxt = r_outs;
        unique case ({w_gnt, w_rvalid})
            2'b10:   w_outs_nxt = r_outs + CW'(1);
            2'b01:   w_outs_nxt = r_outs - CW'(1);
            default: w_outs_nxt = r_outs;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outs <= '0;
        end else begin
            r_outs <= w_outs_nxt;
        end
    end
endmodule

// File: tb/tb_ibex_wb_bridge.sv
// Directed self-checking bench for ibex_wb_bridge (MAX_OUTS=2).
// Checks reset, read, write, stall, pipelining, error and stray ack.
module tb_ibex_wb_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    ibex_wb_bridge_if #(.AW(32), .DW(32)) bus ();

    ibex_wb_bridge #(.MAX_OUTS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef IBEX_WB_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic idle();
        bus.req_i      = 1'b0;
        bus.addr_i     = '0;
        bus.we_i       = 1'b0;
        bus.be_i       = 4'hf;
        bus.wdata_i    = '0;
        bus.wb_dat_i   = '0;
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        bus.wb_stall_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        bus.we_i   = 1'b0;
        bus.be_i   = 4'hf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [31:0] d);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = d;
    endtask

    initial begin
        idle();
        bus.req_i = 1'b1;
        bus.addr_i = 32'h55;
        #2;
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        idle();
        step();
        rst_n = 1'b1;
        step();

        // single read
        rd(32'h100);
        @(negedge clk);
        chk("rd_gnt", bus.gnt_o, 1);
        chk("rd_stb", bus.wb_stb_o, 1);
        chk("rd_adr", bus.wb_adr_o, 32'h100);
        chk("rd_we", bus.wb_we_o, 0);
        step();
        idle();
        ack(32'hDEADBEEF);
        @(negedge clk);
        chk("rd_rvalid", bus.rvalid_o, 1);
        chk("rd_rdata", bus.rdata_o, 32'hDEADBEEF);
        chk("rd_cyc_held", bus.wb_cyc_o, 1);
        chk("rd_err", bus.err_o, 0);
        step();
        idle();
        @(negedge clk);
        chk("rd_cyc_drop", bus.wb_cyc_o, 0);
        chk("rd_rv_drop", bus.rvalid_o, 0);
        step();

        // write
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 32'h2000_0004;
        bus.be_i    = 4'b0011;
        bus.wdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("wr_sel", bus.wb_sel_o, 4'b0011);
        chk("wr_we", bus.wb_we_o, 1);
        chk("wr_dat", bus.wb_dat_o, 32'h1234_5678);
        chk("wr_adr", bus.wb_adr_o, 32'h2000_0004);
        chk("wr_gnt", bus.gnt_o, 1);
        step();
        idle();
        ack(32'h0);
        @(negedge clk);
        chk("wr_rvalid", bus.rvalid_o, 1);
        chk("wr_err", bus.err_o, 0);
        step();
        idle();

        // stall 3 cycles
        rd(32'h40);
        bus.wb_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("st_gnt%0d", i), bus.gnt_o, 0);
            chk($sformatf("st_stb%0d", i), bus.wb_stb_o, 1);
            step();
        end
        bus.wb_stall_i = 1'b0;
        @(negedge clk);
        chk("st_gnt4", bus.gnt_o, 1);
        step();
        idle();
        ack(32'h4040);
        @(negedge clk);
        chk("st_rvalid", bus.rvalid_o, 1);
        chk("st_rdata", bus.rdata_o, 32'h4040);
        step();
        idle();

        // pipelining, ack 2 cycles after grant
        rd(32'h10);
        @(negedge clk);
        chk("pp_gnt_a", bus.gnt_o, 1);
        step();
        rd(32'h14);
        @(negedge clk);
        chk("pp_gnt_b", bus.gnt_o, 1);
        chk("pp_rv_b", bus.rvalid_o, 0);
        step();
        rd(32'h18);
        ack(32'hA);
        @(negedge clk);
        chk("pp_full_stb", bus.wb_stb_o, 0);
        chk("pp_full_gnt", bus.gnt_o, 0);
        chk("pp_cyc", bus.wb_cyc_o, 1);
        chk("pp_rv_a", bus.rvalid_o, 1);
        chk("pp_rd_a", bus.rdata_o, 32'hA);
        step();
        ack(32'hB);
        @(negedge clk);
        chk("pp_gnt_c", bus.gnt_o, 1);
        chk("pp_rv_bb", bus.rvalid_o, 1);
        chk("pp_rd_b", bus.rdata_o, 32'hB);
        step();
        idle();
        ack(32'hC);
        @(negedge clk);
        chk("pp_rv_c", bus.rvalid_o, 1);
        chk("pp_rd_c", bus.rdata_o, 32'hC);
        step();
        idle();
        @(negedge clk);
        chk("pp_cyc_drop", bus.wb_cyc_o, 0);
        step();

        // error response
        rd(32'h80);
        @(negedge clk);
        chk("er_gnt", bus.gnt_o, 1);
        step();
        idle();
        bus.wb_err_i = 1'b1;
        @(negedge clk);
        chk("er_rvalid", bus.rvalid_o, 1);
        chk("er_err", bus.err_o, EXP_ERR);
        step();
        idle();
        @(negedge clk);
        chk("er_cyc_drop", bus.wb_cyc_o, 0);

        // stray ack ignored
        ack(32'h77);
        @(negedge clk);
        chk("stray_rv", bus.rvalid_o, 0);
        chk("stray_cyc", bus.wb_cyc_o, 0);
        step();
        idle();

        // reset mid-transfer
        rd(32'hC0);
        @(negedge clk);
        chk("rm_gnt", bus.gnt_o, 1);
        step();
        @(negedge clk);
        chk("rm_cyc_pre", bus.wb_cyc_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_cyc", bus.wb_cyc_o, 0);
        chk("rm_stb", bus.wb_stb_o, 0);
        chk("rm_gnt0", bus.gnt_o, 0);
        chk("rm_adr", bus.wb_adr_o, 0);
        step();
        idle();
        rst_n = 1'b1;
        ack(32'h99);
        @(negedge clk);
        chk("rm_no_rv", bus.rvalid_o, 0);
        chk("rm_cyc_post", bus.wb_cyc_o, 0);
        step();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
